// File: rtl/key_sel_pkg.sv
// Shared types and constants for the AES key-path arbiter.
package key_sel_pkg;

    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [1:0] AES0 = 2'd0;
    localparam logic [1:0] AES1 = 2'd1;
    localparam logic [1:0] AES2 = 2'd2;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    // Smallest r with 2**r >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/key_sel_arbiter_if.sv
// Request/AXI-valid lines in, key selection and status out.
interface key_sel_arbiter_if import key_sel_pkg::*; #(
    parameter int unsigned NUM_IP = 3,
    parameter int unsigned IDX_W  = (clog2(NUM_IP) > 1) ? clog2(NUM_IP) : 1
);
    logic [NUM_IP-1:0] ip_req;
    logic [NUM_IP-1:0] ip_axi_aw_valid;
    logic [NUM_IP-1:0] ip_axi_ar_valid;
    logic              txn_done;
    logic [IDX_W-1:0]  key_o;
    logic              key_valid;
    logic [NUM_IP-1:0] grant;
    logic              rd_wr;
    logic              busy;
    logic              timeout_err;

    modport master (
        output ip_req, ip_axi_aw_valid, ip_axi_ar_valid, txn_done,
        input  key_o, key_valid, grant, rd_wr, busy, timeout_err
    );

    modport slave (
        input  ip_req, ip_axi_aw_valid, ip_axi_ar_valid, txn_done,
        output key_o, key_valid, grant, rd_wr, busy, timeout_err
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational winner search: first request at or above rr_ptr (mode=1) or lowest request.
module rr_pick import key_sel_pkg::*; #(
    parameter int unsigned NUM_IP = 3,
    parameter int unsigned IDX_W  = (clog2(NUM_IP) > 1) ? clog2(NUM_IP) : 1
) (
    input  logic [NUM_IP-1:0] req,
    input  logic [IDX_W-1:0]  rr_ptr,
    input  logic              mode,
    output logic [IDX_W-1:0]  winner,
    output logic              found
);
    logic [IDX_W-1:0]  base;
    logic [NUM_IP-1:0] rot;
    logic [IDX_W:0]    sum;

    always_comb begin
        base  = mode ? rr_ptr : '0;
        rot   = NUM_IP'({req, req} >> base);
        found = |rot;
        sum   = '0;
        // Descending scan so the lowest rotated position is the one that sticks.
        for (int k = NUM_IP - 1; k >= 0; k--) begin
            if (rot[k]) sum = {1'b0, base} + (IDX_W + 1)'(k);
        end
        if (sum >= (IDX_W + 1)'(NUM_IP)) sum = sum - (IDX_W + 1)'(NUM_IP);
        winner = sum[IDX_W-1:0];
    end
endmodule

// File: rtl/key_sel_arbiter.sv
// Grants the shared AES key path to one of NUM_IP cores and holds it until done or timeout.
module key_sel_arbiter import key_sel_pkg::*; #(
    parameter int unsigned NUM_IP      = 3,
    parameter int unsigned IDX_W       = (clog2(NUM_IP) > 1) ? clog2(NUM_IP) : 1,
    parameter int unsigned ROUND_ROBIN = 1,
    parameter int unsigned HOLD_MAX    = 16
) (
    input logic              clk,
    input logic              reset,
    key_sel_arbiter_if.slave bus
);
    localparam int unsigned      CNT_W    = (clog2(HOLD_MAX + 1) > 1) ? clog2(HOLD_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
    localparam logic [IDX_W-1:0] KEY_TOP  = IDX_W'(NUM_IP - 1);
    localparam logic [NUM_IP-1:0] ONE     = NUM_IP'(1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  key_q, key_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_IP-1:0] grant_q, grant_d;
    logic              kv_q, kv_d;
    logic              rdwr_q, rdwr_d;
    logic              busy_q, busy_d;
    logic              terr_q, terr_d;
    logic [IDX_W-1:0]  winner;
    logic              found;
    logic              timeout_hit;

    rr_pick #(
        .NUM_IP (NUM_IP),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req    (bus.ip_req),
        .rr_ptr (ptr_q),
        .mode   (ROUND_ROBIN != 0),
        .winner (winner),
        .found  (found)
    );

    assign timeout_hit = (HOLD_MAX != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        kv_d    = kv_q;
        rdwr_d  = rdwr_q;
        busy_d  = busy_q;
        terr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = LOCKED;
                    key_d   = winner;
                    grant_d = ONE << winner;
                    kv_d    = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            LOCKED: begin
                // Only the owner's channel is observed; read wins a tie.
                if (bus.ip_axi_ar_valid[key_q])      rdwr_d = RD;
                else if (bus.ip_axi_aw_valid[key_q]) rdwr_d = WR;
                if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
                if (bus.txn_done || timeout_hit) begin
                    state_d = IDLE;
                    grant_d = '0;
                    kv_d    = 1'b0;
                    busy_d  = 1'b0;
                    terr_d  = !bus.txn_done;
                    if (ROUND_ROBIN != 0) ptr_d = (key_q == KEY_TOP) ? '0 : key_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            kv_q    <= 1'b0;
            rdwr_q  <= RD;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            kv_q    <= kv_d;
            rdwr_q  <= rdwr_d;
            busy_q  <= busy_d;
            terr_q  <= terr_d;
        end
    end

    assign bus.key_o       = key_q;
    assign bus.key_valid   = kv_q;
    assign bus.grant       = grant_q;
    assign bus.rd_wr       = rdwr_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = terr_q;
endmodule

// File: doc/key_sel_arbiter.md
Name: key_sel_arbiter

Overview:
- Parametrised successor of the three-way AES key/channel selector.
- Arbitrates among NUM_IP requesting IP cores for ownership of the shared AES key path.
- Holds the grant until the transaction completes or times out, and reports read/write direction from the owner's AXI address-channel valids.
- Sits between the IP-side request/AXI-valid lines and the key mux / crypto datapath.

Parameters:
- NUM_IP, 3, number of requesting IP channels; legal range 2..16.
- IDX_W, max(1,$clog2(NUM_IP)), width of the key index output.
- ROUND_ROBIN, 1: 1 selects round-robin arbitration; 0 selects fixed priority, where the lowest index wins.
- HOLD_MAX, 16, maximum cycles in LOCKED before forced release; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous active-low reset
- ip_req  in  NUM_IP  per-IP request for the key path, level
- ip_axi_aw_valid  in  NUM_IP  per-IP AXI write-address valid
- ip_axi_ar_valid  in  NUM_IP  per-IP AXI read-address valid
- txn_done  in  1  single-cycle pulse from the datapath: owner's transaction complete
- key_o  out  IDX_W  index of the granted IP / AES key
- key_valid  out  1  key_o is valid and locked
- grant  out  NUM_IP  one-hot grant, zero when idle
- rd_wr  out  1  direction of the owner's access: 0 = read, 1 = write
- busy  out  1  high in LOCKED
- timeout_err  out  1  single-cycle pulse on forced release

Behaviour:
- Reset (reset=0, asynchronous): key_o=0, key_valid=0, grant=0, rd_wr=0, busy=0, timeout_err=0, rr_ptr=0, hold_cnt=0, state=IDLE.
- All outputs are registered.
- States: IDLE and LOCKED.
- IDLE, no ip_req bit set: all outputs hold. key_o and rd_wr retain their last values; key_valid=0.
- IDLE, any ip_req bit set: the winner is chosen combinationally.
  - Round-robin mode: first set bit at or above rr_ptr, wrapping modulo NUM_IP.
  - Fixed mode: lowest set bit.
  - Next edge: state=LOCKED, key_o=winner, grant=onehot(winner), key_valid=1, busy=1, hold_cnt=0.
  - Latency from request to grant is 1 cycle.
- LOCKED, every cycle: rd_wr samples the owner's channel.
  - ip_axi_ar_valid[key_o]=1 gives rd_wr<=0; read has priority when both valids are high.
  - Otherwise ip_axi_aw_valid[key_o]=1 gives rd_wr<=1.
  - Otherwise rd_wr holds.
  - Valids of non-owner channels are ignored.
- LOCKED: hold_cnt increments by 1 each cycle and saturates at HOLD_MAX.
- LOCKED, txn_done=1: next edge returns to IDLE with grant=0, key_valid=0, busy=0.
  - rr_ptr<=(key_o+1) mod NUM_IP.
  - Fixed mode: rr_ptr is unused and stays 0.
- LOCKED, HOLD_MAX!=0, hold_cnt==HOLD_MAX-1, txn_done=0: next edge forces release exactly like txn_done.
  - timeout_err pulses high for that one cycle.
  - Lock duration is therefore HOLD_MAX cycles.
- txn_done and timeout in the same cycle: txn_done wins; no timeout_err.
- Withdrawing ip_req of the owner while LOCKED does not release; only txn_done or timeout release.
- txn_done while IDLE: ignored.
- No back-to-back re-grant: release always passes through at least one IDLE cycle.
  - Minimum spacing between grants is 2 cycles.
  - In round-robin mode the released owner becomes lowest priority.
- Request bits at indices >= NUM_IP do not exist.
  - key_o never exceeds NUM_IP-1, including the wrap from NUM_IP-1 to 0.
- Reset asserted mid-LOCKED: immediate return to reset values. No timeout_err; no pointer update retained.

Decomposition:
- Package key_sel_pkg holds:
  - state enum {IDLE, LOCKED};
  - AES index constants AES0..AES2;
  - RD=1'b0 and WR=1'b1 direction constants;
  - clog2 helper function.
- Sub-module rr_pick:
  - purely combinational;
  - inputs: req vector, rr_ptr, mode;
  - outputs: winner index and found flag;
  - parametrised by NUM_IP.
- Top level holds the FSM, hold counter, pointer and output registers.

Test Plan:
- Reset then ip_req=3'b010, ar_valid[1]=1 -> 1 cycle later key_o=1, grant=3'b010, key_valid=1, busy=1; next cycle rd_wr=0.
- ROUND_ROBIN=1, ip_req=3'b111 held, txn_done pulsed 3 cycles after each grant -> grant order 0,1,2,0, each separated by 1 IDLE cycle.
- ROUND_ROBIN=0, same stimulus as the round-robin scenario -> key_o=0 every grant.
- Owner 2 locked; aw_valid[2]=1, then ar_valid[0]=1 and aw_valid[0]=0 -> rd_wr=1 and stays 1, since channel 0 is ignored.
- HOLD_MAX=4, grant to IP1 with no txn_done -> release after 4 LOCKED cycles; timeout_err high 1 cycle; rr_ptr=2.
- Boundaries:
  - txn_done on the timeout cycle -> no timeout_err.
  - reset pulled low mid-LOCKED -> outputs 0 asynchronously, before the next clk edge.
  - NUM_IP=5 with ip_req=5'b10000 and rr_ptr=4, after a grant at index 3 -> key_o=4; then after txn_done, rr_ptr wraps to 0.
